// File: rtl/loop_recorder.sv
// Looper core: records strobed audio samples into an external async SRAM and
// plays them back as a loop, mixed with the live input and saturated.
module loop_recorder #(
   parameter int          ADDR_W  = 20,
   parameter int          DATA_W  = 16,
   parameter int unsigned MAX_LEN = 20'hFFFFF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_record,
   input  logic              i_play,
   input  logic              i_sample_valid,
   input  logic [DATA_W-1:0] i_sample,
   output logic [DATA_W-1:0] o_sample,
   output logic              o_sample_valid,
   output logic [ADDR_W-1:0] o_SRAM_ADDR,
   inout  wire  [DATA_W-1:0] io_SRAM_DQ,
   output logic              o_SRAM_WE_N,
   output logic              o_SRAM_CE_N,
   output logic              o_SRAM_OE_N,
   output logic              o_SRAM_LB_N,
   output logic              o_SRAM_UB_N,
   output logic [ADDR_W-1:0] o_loop_len,
   output logic              o_full,
   output logic              o_overrun
);

   localparam logic [ADDR_W-1:0] MaxLen = ADDR_W'(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_DONE} state_t;
   typedef enum logic [1:0] {M_PASS, M_PLAY, M_REC} mode_t;

   state_t                    state_q, state_d;
   mode_t                     mode_q, mode_d;
   logic                      wr_en_q, wr_en_d;
   logic                      prev_rec_q, prev_rec_d;
   logic signed [DATA_W-1:0]  sample_q, sample_d;
   logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic [ADDR_W-1:0]         len_q, len_d;
   logic                      full_q, full_d;
   logic signed [DATA_W-1:0]  out_q, out_d;
   logic                      out_vld_q, out_vld_d;
   logic                      ovr_q, ovr_d;

   function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
      logic signed [DATA_W:0] s;
      s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
      if (s[DATA_W] != s[DATA_W-1])
         sat_add = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
         sat_add = s[DATA_W-1:0];
   endfunction

   // Mode transitions take effect on the strobe itself, so the pointers and
   // length seen by this access already reflect entering/leaving REC.
   logic              entering, leaving;
   logic [ADDR_W-1:0] eff_wr, eff_rd, eff_len;
   assign entering = i_record && !prev_rec_q;
   assign leaving  = !i_record && prev_rec_q;
   assign eff_wr   = entering ? '0 : wr_ptr_q;
   assign eff_rd   = leaving ? '0 : rd_ptr_q;
   assign eff_len  = leaving ? wr_ptr_q : len_q;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      wr_en_d    = wr_en_q;
      prev_rec_d = prev_rec_q;
      sample_d   = sample_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      addr_d     = addr_q;
      len_d      = len_q;
      full_d     = full_q;
      out_d      = out_q;
      out_vld_d  = 1'b0;
      ovr_d      = i_sample_valid && (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (i_sample_valid) begin
               state_d    = S_ACC1;
               sample_d   = i_sample;
               prev_rec_d = i_record;
               wr_en_d    = 1'b0;
               mode_d     = M_PASS;
               if (leaving) begin
                  len_d    = wr_ptr_q;
                  rd_ptr_d = '0;
               end
               if (i_record) begin
                  mode_d = M_REC;
                  if (entering) begin
                     wr_ptr_d = '0;
                     full_d   = 1'b0;
                     len_d    = '0;
                  end
                  if (eff_wr == MaxLen) begin
                     full_d = 1'b1;
                     len_d  = MaxLen;
                  end else begin
                     wr_en_d = 1'b1;
                     addr_d  = eff_wr;
                  end
               end else if (i_play && (eff_len != '0)) begin
                  mode_d = M_PLAY;
                  addr_d = eff_rd;
               end
            end
         end
         S_ACC1: state_d = S_ACC2;
         S_ACC2: begin
            state_d   = S_DONE;
            out_vld_d = 1'b1;
            out_d     = (mode_q == M_PLAY) ? sat_add(sample_q, io_SRAM_DQ) : sample_q;
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (wr_en_q)
               wr_ptr_d = wr_ptr_q + 1'b1;
            if (mode_q == M_PLAY)
               rd_ptr_d = (rd_ptr_q == len_q - 1'b1) ? '0 : rd_ptr_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         mode_q     <= M_PASS;
         wr_en_q    <= 1'b0;
         prev_rec_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         full_q     <= 1'b0;
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         wr_en_q    <= wr_en_d;
         prev_rec_q <= prev_rec_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         full_q     <= full_d;
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         ovr_q      <= ovr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      sample_q <= sample_d;
   end

   // SRAM strobes decode straight from state so a reset drops them on its own edge.
   logic acc, wr_act, rd_act;
   assign acc    = (state_q == S_ACC1) || (state_q == S_ACC2);
   assign wr_act = acc && (mode_q == M_REC) && wr_en_q;
   assign rd_act = acc && (mode_q == M_PLAY);

   assign io_SRAM_DQ     = wr_act ? sample_q : {DATA_W{1'bz}};
   assign o_SRAM_ADDR    = addr_q;
   assign o_SRAM_WE_N    = !wr_act;
   assign o_SRAM_OE_N    = !rd_act;
   assign o_SRAM_CE_N    = !(wr_act || rd_act);
   assign o_SRAM_LB_N    = !(wr_act || rd_act);
   assign o_SRAM_UB_N    = !(wr_act || rd_act);
   assign o_sample       = out_q;
   assign o_sample_valid = out_vld_q;
   assign o_loop_len     = len_q;
   assign o_full         = full_q;
   assign o_overrun      = ovr_q;

endmodule

// File: tb/tb_loop_recorder.sv
// Scoreboarded random/directed bench for loop_recorder with a behavioural SRAM.
module tb_loop_recorder;

   localparam int AW   = 8;
   localparam int DW   = 16;
   localparam int MAXL = 200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, rec, play, vld;
   logic [DW-1:0] smp;
   logic [DW-1:0] o_smp;
   logic          o_vld, we_n, ce_n, oe_n, lb_n, ub_n, full, ovr;
   logic [AW-1:0] addr, len;
   wire  [DW-1:0] dq;

   logic [DW-1:0] sram [0:(1<<AW)-1];
   assign dq = (!ce_n && !oe_n && we_n) ? sram[addr] : {DW{1'bz}};
   always @(negedge clk) if (!ce_n && !we_n) sram[addr] = dq;

   loop_recorder #(.ADDR_W(AW), .DATA_W(DW), .MAX_LEN(MAXL)) dut (
      .i_clk(clk), .i_rst(rst), .i_record(rec), .i_play(play),
      .i_sample_valid(vld), .i_sample(smp), .o_sample(o_smp), .o_sample_valid(o_vld),
      .o_SRAM_ADDR(addr), .io_SRAM_DQ(dq), .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n),
      .o_SRAM_OE_N(oe_n), .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n),
      .o_loop_len(len), .o_full(full), .o_overrun(ovr));

   // Small instance for the MAX_LEN limit.
   logic          s_vld;
   logic [DW-1:0] s_smp, s_osmp;
   logic          s_ovld, s_we_n, s_ce_n, s_oe_n, s_lb_n, s_ub_n, s_full, s_ovr;
   logic [3:0]    s_addr, s_len;
   wire  [DW-1:0] s_dq;

   loop_recorder #(.ADDR_W(4), .DATA_W(DW), .MAX_LEN(3)) dut_small (
      .i_clk(clk), .i_rst(rst), .i_record(1'b1), .i_play(1'b0),
      .i_sample_valid(s_vld), .i_sample(s_smp), .o_sample(s_osmp), .o_sample_valid(s_ovld),
      .o_SRAM_ADDR(s_addr), .io_SRAM_DQ(s_dq), .o_SRAM_WE_N(s_we_n), .o_SRAM_CE_N(s_ce_n),
      .o_SRAM_OE_N(s_oe_n), .o_SRAM_LB_N(s_lb_n), .o_SRAM_UB_N(s_ub_n),
      .o_loop_len(s_len), .o_full(s_full), .o_overrun(s_ovr));

   int n_vec = 0, n_miss = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: loop state kept as plain integers and an array.
   typedef struct {
      logic [DW-1:0] out;
      int            kind;   // 0 none, 1 write, 2 read
      int            addr;
      logic [DW-1:0] wdata;
      int            len;
      bit            full;
   } exp_t;
   exp_t exp_q[$];

   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   bit m_prev_rec, m_full;
   int m_wr, m_rd, m_len;

   function automatic void model_reset();
      m_prev_rec = 0; m_full = 0; m_wr = 0; m_rd = 0; m_len = 0;
   endfunction

   function automatic void model(bit r, bit p, logic [DW-1:0] s);
      exp_t e;
      int v;
      e.kind = 0; e.addr = 0; e.wdata = s; e.out = s;
      if (m_prev_rec && !r) begin m_len = m_wr; m_rd = 0; end
      if (r) begin
         if (!m_prev_rec) begin m_wr = 0; m_full = 0; m_len = 0; end
         if (m_wr == MAXL) begin
            m_full = 1; m_len = MAXL;
         end else begin
            ref_mem[m_wr] = s; e.kind = 1; e.addr = m_wr; m_wr++;
         end
      end else if (p && m_len != 0) begin
         v = int'($signed(s)) + int'($signed(ref_mem[m_rd]));
         if (v > 32767) v = 32767;
         if (v < -32768) v = -32768;
         e.out = v[DW-1:0]; e.kind = 2; e.addr = m_rd;
         m_rd = (m_rd + 1) % m_len;
      end
      m_prev_rec = r;
      e.len = m_len; e.full = m_full;
      exp_q.push_back(e);
   endfunction

   // Monitor: tallies SRAM activity per access, compares on each output strobe.
   int wr_cyc = 0, rd_cyc = 0, acc_addr = 0, ovr_cnt = 0;
   logic [DW-1:0] acc_data = '0;
   always @(negedge clk) begin
      exp_t e;
      if (ovr) ovr_cnt++;
      if (rst) begin
         wr_cyc = 0; rd_cyc = 0;
      end else begin
         if (!ce_n && !we_n) begin wr_cyc++; acc_addr = int'(addr); acc_data = dq; end
         if (!ce_n && !oe_n) begin rd_cyc++; acc_addr = int'(addr); end
         if (o_vld) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'(o_vld), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("o_sample", 32'(o_smp), 32'(e.out));
               check("write_cycles", 32'(wr_cyc), (e.kind == 1) ? 32'd2 : 32'd0);
               check("read_cycles", 32'(rd_cyc), (e.kind == 2) ? 32'd2 : 32'd0);
               if (e.kind != 0) check("sram_addr", 32'(acc_addr), 32'(e.addr));
               if (e.kind == 1) check("write_data", 32'(acc_data), 32'(e.wdata));
               check("loop_len", 32'(len), 32'(e.len));
               check("full", 32'(full), 32'(e.full));
            end
            wr_cyc = 0; rd_cyc = 0;
         end
      end
   end

   int s_wr_cyc = 0;
   always @(negedge clk) if (!s_we_n) s_wr_cyc++;

   task automatic send(input bit r, input bit p, input logic [DW-1:0] s);
      @(negedge clk);
      rec = r; play = p; smp = s; vld = 1'b1;
      model(r, p, s);
      @(negedge clk);
      vld = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int ovr_before, t;
      rst = 1'b1; rec = 1'b0; play = 1'b0; vld = 1'b0; smp = '0;
      s_vld = 1'b0; s_smp = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_sample", 32'(o_smp), 32'd0);
      check("rst_valid", 32'(o_vld), 32'd0);
      check("rst_strobes", {27'd0, we_n, ce_n, oe_n, lb_n, ub_n}, 32'h1F);
      check("rst_addr", 32'(addr), 32'd0);
      check("rst_len", 32'(len), 32'd0);
      check("rst_full_ovr", {30'd0, full, ovr}, 32'd0);
      rst = 1'b0;

      // Play with an empty loop behaves as pass-through.
      send(1'b0, 1'b1, 16'd55);
      check("pass_no_strobe", 32'(ce_n), 32'd1);

      // Record four, then play five with wrap.
      send(1'b1, 1'b0, 16'd100);
      send(1'b1, 1'b0, 16'd200);
      send(1'b1, 1'b0, 16'd300);
      send(1'b1, 1'b0, 16'd400);
      for (int i = 0; i < 5; i++) send(1'b0, 1'b1, 16'd0);
      check("len_after_rec4", 32'(len), 32'd4);

      // Saturation, with record+play together acting as record.
      send(1'b1, 1'b0, 16'h7000);
      send(1'b1, 1'b1, 16'h9000);
      send(1'b0, 1'b1, 16'h2000);
      send(1'b0, 1'b1, 16'hA000);
      repeat (3) @(negedge clk);
      check("sat_neg_hold", 32'(o_smp), 32'h8000);

      // Overrun: second strobe two cycles after the first.
      ovr_before = ovr_cnt;
      @(negedge clk);
      rec = 1'b0; play = 1'b1; smp = 16'd5; vld = 1'b1;
      model(1'b0, 1'b1, 16'd5);
      @(negedge clk); vld = 1'b0;
      check("valid_early", 32'(o_vld), 32'd0);
      @(negedge clk); vld = 1'b1; smp = 16'd9;
      @(negedge clk); vld = 1'b0;
      check("valid_at_3", 32'(o_vld), 32'd1);
      check("overrun_pulse", 32'(ovr), 32'd1);
      @(negedge clk);
      check("overrun_once", 32'(ovr_cnt - ovr_before), 32'd1);
      repeat (2) @(negedge clk);

      // Random mix of modes and samples.
      for (int i = 0; i < 80; i++) begin
         send($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, 16'($urandom_range(0, 65535)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset during ACC2 of a write aborts it.
      @(negedge clk); rec = 1'b1; play = 1'b0; smp = 16'd77; vld = 1'b1;
      @(negedge clk); vld = 1'b0;
      @(negedge clk);
      check("we_low_acc2", 32'(we_n), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_we_high", 32'(we_n), 32'd1);
      check("abort_len", 32'(len), 32'd0);
      check("abort_no_valid", 32'(o_vld), 32'd0);
      rst = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);

      // MAX_LEN = 3 instance: five record strobes.
      s_wr_cyc = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); s_smp = 16'(i + 1); s_vld = 1'b1;
         @(negedge clk); s_vld = 1'b0;
         repeat (2) @(negedge clk);
      end
      check("small_write_cycles", 32'(s_wr_cyc), 32'd6);
      check("small_full", 32'(s_full), 32'd1);
      check("small_len", 32'(s_len), 32'd3);

      t = 0;
      while (exp_q.size() != 0 && t < 50) begin @(negedge clk); t++; end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/loop_recorder.md
LOOP_RECORDER -- requirements
Module: loop_recorder

Interface
REQ-001 Parameter ADDR_W, default 20: SRAM address width.
REQ-002 Parameter DATA_W, default 16: sample and SRAM data width.
REQ-003 Parameter MAX_LEN, default 20'hFFFFF: maximum loop length in samples; must not exceed 2^ADDR_W-1.
REQ-004 i_clk  input  1  single block clock; all logic on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_record  input  1  level; high selects record mode.
REQ-007 i_play  input  1  level; high selects loop-play mode.
REQ-008 i_sample_valid  input  1  one-cycle strobe, one per audio frame.
REQ-009 i_sample  input  DATA_W  signed input sample, qualified by i_sample_valid.
REQ-010 o_sample  output  DATA_W  signed output sample.
REQ-011 o_sample_valid  output  1  one-cycle strobe qualifying o_sample.
REQ-012 o_SRAM_ADDR  output  ADDR_W  SRAM address.
REQ-013 io_SRAM_DQ  inout  DATA_W  SRAM data; driven only during writes, else high-Z.
REQ-014 o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  output  1 each  active-low SRAM strobes.
REQ-015 o_loop_len  output  ADDR_W  number of samples in the stored loop.
REQ-016 o_full  output  1  high when the last recording hit MAX_LEN.
REQ-017 o_overrun  output  1  one-cycle pulse when a strobe arrives during a busy access.

Function
REQ-018 Mode per strobe: i_record high -> REC (wins when i_play also high); else i_play high with o_loop_len != 0 -> PLAY; else PASS.
REQ-019 Access FSM states: IDLE, ACC1, ACC2, DONE; IDLE->ACC1 on i_sample_valid, ACC1->ACC2->DONE->IDLE unconditionally.
REQ-020 The mode, i_sample and a pointer snapshot are captured on the cycle i_sample_valid is sampled in IDLE.
REQ-021 o_sample_valid is high for exactly one cycle, during DONE, three cycles after the accepted strobe, in every mode.
REQ-022 i_sample_valid arriving in ACC1, ACC2 or DONE is dropped and o_overrun pulses in the following cycle.
REQ-023 REC: during ACC1 and ACC2, o_SRAM_ADDR = wr_ptr, io_SRAM_DQ = captured sample, CE_N = WE_N = LB_N = UB_N = 0, OE_N = 1; wr_ptr increments in DONE.
REQ-024 REC: o_sample = captured input sample (monitor).
REQ-025 Entering REC from any other mode (first REC strobe) clears wr_ptr to 0, o_full to 0 and o_loop_len to 0 before the write.
REQ-026 REC full: when wr_ptr == MAX_LEN no write occurs (strobes remain inactive high), o_full = 1, o_loop_len = MAX_LEN.
REQ-027 Leaving REC (first non-REC strobe) latches o_loop_len = wr_ptr and clears rd_ptr to 0.
REQ-028 PLAY: during ACC1 and ACC2, o_SRAM_ADDR = rd_ptr, CE_N = OE_N = LB_N = UB_N = 0, WE_N = 1, DQ high-Z; SRAM data latched at the end of ACC2.
REQ-029 PLAY: o_sample = saturate(captured input + SRAM data), computed at DATA_W+1 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-030 PLAY: rd_ptr increments in DONE and wraps to 0 when rd_ptr == o_loop_len-1.
REQ-031 PASS: o_sample = captured input; no SRAM strobe asserted; rd_ptr is held.
REQ-032 Outside ACC1/ACC2 all SRAM strobes are high, DQ is high-Z, and o_SRAM_ADDR holds its last value.
REQ-033 o_sample holds its value between o_sample_valid pulses.
REQ-034 o_loop_len and the stored loop persist across PASS and PLAY until the next REC entry.

Reset
REQ-035 On i_rst high at a rising edge: FSM -> IDLE, wr_ptr = rd_ptr = 0, o_loop_len = 0, o_full = 0, o_sample = 0, o_sample_valid = 0, o_overrun = 0, o_SRAM_ADDR = 0, all SRAM strobes = 1, DQ high-Z.
REQ-036 Reset mid-access aborts it: strobes return high on the reset edge and no pointer update occurs.

Verification
REQ-037 Record 4 strobes (samples 100, 200, 300, 400), then play -> writes at addresses 0..3 with WE_N low 2 cycles each; o_loop_len = 4; playback with input 0 yields 100, 200, 300, 400, 100 (wrap).
REQ-038 PLAY with stored sample 16'h7000 and input 16'h2000 -> o_sample = 16'h7FFF; stored 16'h9000 with input 16'hA000 -> 16'h8000.
REQ-039 Strobe, then second strobe 2 cycles later -> first o_sample_valid exactly 3 cycles after first strobe; o_overrun pulses once; only one SRAM access.
REQ-040 MAX_LEN = 3; record 5 strobes -> exactly 3 writes, o_full = 1, o_loop_len = 3.
REQ-041 i_record and i_play both high -> REC behaviour; i_play high with o_loop_len = 0 -> PASS, no SRAM strobe.
REQ-042 i_rst asserted during ACC2 of a write -> WE_N = 1 next cycle, o_loop_len = 0, no o_sample_valid.
